// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice is reused across a WIDTH-bit add,
// one bit per clock LSB-first, with the carry held in a flop between bits.

// Single-bit full adder cell.
module prim_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             car_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic fa_s;
    logic fa_c;

    prim_full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Next-state logic: operand capture, per-bit shifting and result commit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = car_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                if (cnt_q == LastCnt) begin
                    // Final bit is folded in here so the commit needs no extra cycle.
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any add in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_out  = (state_q == StRun);
    assign done_out  = (state_q == StDone);
    assign sum_out   = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a scoreboard of expected {carry, sum} results.

module tb_serial_add_ctrl;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .start_in  (start),
        .a_in      (a),
        .b_in      (b),
        .car_in    (cin),
        .busy_out  (busy),
        .done_out  (done),
        .sum_out   (sum),
        .carry_out (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the current outputs.
    task automatic check_result(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 64'(sum), 64'(e[W-1:0]));
            check({tag, "_carry"}, 64'(cout), 64'(e[W]));
        end
    endtask

    // One complete add from IDLE; optionally pulses start with junk operands during RUN.
    task automatic run_add(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic ci, input logic [W-1:0] hold, input int inject_cyc);
        int cyc;
        int busy_n;
        int extra_done;
        logic seen;
        logic [W-1:0] hold_obs;
        @(negedge clk);
        start = 1'b1;
        a = ai;
        b = bi;
        cin = ci;
        exp_q.push_back({1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci});
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        cyc = 1;
        busy_n = 0;
        seen = 1'b0;
        hold_obs = hold;
        while (cyc <= 30) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (sum !== hold && hold_obs === hold) hold_obs = sum;
            if (cyc == inject_cyc) begin
                start = 1'b1;
                a = 8'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        check({tag, "_hold"}, 64'(hold_obs), 64'(hold));
        check_result(tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
        extra_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({tag, "_no_extra_done"}, 64'(extra_done), 64'd0);
    endtask

    initial begin
        int cyc;
        int n;
        int gap;
        logic seen;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #23 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_carry", 64'(cout), 64'd0);

        run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h00, 0);
        run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h96, 0);
        run_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'h00, 0);
        run_add("ignore_start", 8'h10, 8'h20, 1'b0, 8'hFF, 3);

        // Asynchronous reset in the middle of RUN cycle 4.
        @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_carry", 64'(cout), 64'd0);
        #1 rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);

        run_add("after_abort", 8'h03, 8'h04, 1'b0, 8'h00, 0);

        // Back-to-back: second start accepted on the DONE cycle.
        @(negedge clk);
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        exp_q.push_back(9'h080 + 9'h080);
        cyc = 0;
        seen = 1'b0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        check("b2b_first_latency", 64'(cyc), 64'(W + 1));
        check_result("b2b_first");
        a = 8'h7F;
        b = 8'h01;
        exp_q.push_back(9'h07F + 9'h001);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", 64'(busy), 64'd1);
        gap = 1;
        seen = 1'b0;
        while (gap < 30) begin
            @(negedge clk);
            gap++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_second_done", 64'(seen), 64'd1);
        check("b2b_gap", 64'(gap), 64'(W + 1));
        check_result("b2b_second");
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
